// File: rtl/sys_pll_lock_mgr.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for a stable lock, then releases
// a registered system reset; re-arms on timeout or lock loss and latches a hard failure.
module sys_pll_lock_mgr #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int LOCK_STABLE    = 1024,
   parameter int MAX_RETRIES    = 7,
   parameter int CNT_W          = 16
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       lock_ok,
   output logic       pll_fail,
   output logic [2:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   typedef enum logic [2:0] {
      S_PLL_RST,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN,
      S_FAIL
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRIES);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [2:0]       retry_nx;
   logic [7:0]       loss_nx;
   logic             sync1;
   logic             locked_s;

   // Outputs are decoded from the next state so they move on the same edge as the state.
   always_ff @(posedge refclk) begin
      if (rst) begin
         sync1     <= 1'b0;
         locked_s  <= 1'b0;
         state     <= S_PLL_RST;
         cnt       <= '0;
         retry_cnt <= 3'd0;
         loss_cnt  <= 8'd0;
         pll_rst   <= 1'b1;
         sys_rst   <= 1'b1;
         lock_ok   <= 1'b0;
         pll_fail  <= 1'b0;
      end else begin
         sync1     <= pll_locked;
         locked_s  <= sync1;
         state     <= state_nx;
         cnt       <= cnt_nx;
         retry_cnt <= retry_nx;
         loss_cnt  <= loss_nx;
         pll_rst   <= (state_nx == S_PLL_RST) || (state_nx == S_FAIL);
         sys_rst   <= (state_nx != S_RUN);
         lock_ok   <= (state_nx == S_RUN);
         pll_fail  <= (state_nx == S_FAIL);
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      retry_nx = retry_cnt;
      loss_nx  = loss_cnt;
      case (state)
         S_PLL_RST: begin
            if (cnt == RST_LAST) begin
               state_nx = S_WAIT_LOCK;
               cnt_nx   = '0;
            end
         end
         S_WAIT_LOCK: begin
            // A lock seen on the timeout cycle takes priority over the retry.
            if (locked_s) begin
               state_nx = S_STABLE;
               cnt_nx   = '0;
            end else if (cnt == TIMEOUT_LAST) begin
               cnt_nx = '0;
               if (retry_cnt == RETRY_MAX) begin
                  state_nx = S_FAIL;
               end else begin
                  state_nx = S_PLL_RST;
                  retry_nx = retry_cnt + 3'd1;
               end
            end
         end
         S_STABLE: begin
            if (!locked_s) begin
               state_nx = S_WAIT_LOCK;
               cnt_nx   = '0;
            end else if (cnt == STABLE_LAST) begin
               state_nx = S_RUN;
               cnt_nx   = '0;
               retry_nx = 3'd0;
            end
         end
         S_RUN: begin
            cnt_nx = cnt;
            if (!locked_s) begin
               state_nx = S_PLL_RST;
               cnt_nx   = '0;
               if (loss_cnt != 8'hFF) begin
                  loss_nx = loss_cnt + 8'd1;
               end
            end
         end
         S_FAIL: begin
            cnt_nx = cnt;
         end
         default: begin
            state_nx = S_PLL_RST;
            cnt_nx   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_sys_pll_lock_mgr.sv
// Scoreboard bench for sys_pll_lock_mgr: a phase/elapsed-time reference model queues the
// expected outputs after every edge, and a monitor on the falling edge compares them.
module tb_sys_pll_lock_mgr;

   localparam int PLL_RST_CYCLES = 4;
   localparam int LOCK_TIMEOUT   = 100;
   localparam int LOCK_STABLE    = 8;
   localparam int MAX_RETRIES    = 2;

   localparam int PH_RST    = 0;
   localparam int PH_WAIT   = 1;
   localparam int PH_STABLE = 2;
   localparam int PH_RUN    = 3;
   localparam int PH_FAIL   = 4;

   typedef struct packed {
      logic       pll_rst;
      logic       sys_rst;
      logic       lock_ok;
      logic       pll_fail;
      logic [2:0] retry;
      logic [7:0] loss;
   } obs_t;

   logic       refclk;
   logic       rst;
   logic       pll_locked;
   logic       pll_rst;
   logic       sys_rst;
   logic       lock_ok;
   logic       pll_fail;
   logic [2:0] retry_cnt;
   logic [7:0] loss_cnt;

   obs_t exp_q[$];
   obs_t mon_exp;
   obs_t mon_act;
   int   n_compared;
   int   n_mismatched;

   int   ph;
   int   ph_age;
   int   m_retries;
   int   m_losses;
   logic m_s1;
   logic m_s2;

   sys_pll_lock_mgr #(
      .PLL_RST_CYCLES(PLL_RST_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .LOCK_STABLE   (LOCK_STABLE),
      .MAX_RETRIES   (MAX_RETRIES),
      .CNT_W         (16)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .pll_locked(pll_locked),
      .pll_rst   (pll_rst),
      .sys_rst   (sys_rst),
      .lock_ok   (lock_ok),
      .pll_fail  (pll_fail),
      .retry_cnt (retry_cnt),
      .loss_cnt  (loss_cnt)
   );

   initial refclk = 1'b0;
   always #10 refclk = ~refclk;

   task automatic enterPhase(input int p);
      ph     = p;
      ph_age = 0;
   endtask

   // Reference model: advances one edge using the inputs the DUT samples on that edge.
   task automatic modelStep();
      int   spent;
      logic seen;
      seen  = m_s2;
      spent = ph_age + 1;
      if (rst) begin
         enterPhase(PH_RST);
         m_retries = 0;
         m_losses  = 0;
         m_s1      = 1'b0;
         m_s2      = 1'b0;
      end else begin
         ph_age = spent;
         case (ph)
            PH_RST:
               if (spent == PLL_RST_CYCLES) enterPhase(PH_WAIT);
            PH_WAIT:
               if (seen) enterPhase(PH_STABLE);
               else if (spent == LOCK_TIMEOUT) begin
                  if (m_retries == MAX_RETRIES) enterPhase(PH_FAIL);
                  else begin
                     m_retries++;
                     enterPhase(PH_RST);
                  end
               end
            PH_STABLE:
               if (!seen) enterPhase(PH_WAIT);
               else if (spent == LOCK_STABLE) begin
                  enterPhase(PH_RUN);
                  m_retries = 0;
               end
            PH_RUN:
               if (!seen) begin
                  enterPhase(PH_RST);
                  m_losses = (m_losses < 255) ? m_losses + 1 : 255;
               end
            default: ;
         endcase
         m_s2 = m_s1;
         m_s1 = pll_locked;
      end
   endtask

   function automatic obs_t modelObs();
      obs_t o;
      o.pll_rst  = (ph == PH_RST) || (ph == PH_FAIL);
      o.sys_rst  = (ph != PH_RUN);
      o.lock_ok  = (ph == PH_RUN);
      o.pll_fail = (ph == PH_FAIL);
      o.retry    = 3'(m_retries);
      o.loss     = 8'(m_losses);
      return o;
   endfunction

   task automatic applyStimulus(input logic r, input logic l, input int n);
      repeat (n) begin
         @(posedge refclk);
         modelStep();
         exp_q.push_back(modelObs());
         #1;
         rst        = r;
         pll_locked = l;
      end
   endtask

   task automatic checkOutput(input obs_t e, input obs_t a);
      n_compared++;
      if (a !== e) begin
         n_mismatched++;
         $display("[TB] FAIL outputs @%0t: got pll_rst=%b sys_rst=%b lock_ok=%b pll_fail=%b retry=%0d loss=%0d, want pll_rst=%b sys_rst=%b lock_ok=%b pll_fail=%b retry=%0d loss=%0d",
                  $time, a.pll_rst, a.sys_rst, a.lock_ok, a.pll_fail, a.retry, a.loss,
                  e.pll_rst, e.sys_rst, e.lock_ok, e.pll_fail, e.retry, e.loss);
      end
   endtask

   always @(negedge refclk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_act = {pll_rst, sys_rst, lock_ok, pll_fail, retry_cnt, loss_cnt};
         checkOutput(mon_exp, mon_act);
      end
   end

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      ph           = PH_RST;
      ph_age       = 0;
      m_retries    = 0;
      m_losses     = 0;
      m_s1         = 1'b0;
      m_s2         = 1'b0;
      rst          = 1'b1;
      pll_locked   = 1'b0;

      $display("[TB] cold start");
      applyStimulus(1'b1, 1'b0, 3);
      applyStimulus(1'b0, 1'b0, 20);
      applyStimulus(1'b0, 1'b1, 30);

      $display("[TB] no lock, retries to failure");
      applyStimulus(1'b1, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 350);
      applyStimulus(1'b0, 1'b1, 20);

      $display("[TB] lock glitch while stabilising");
      applyStimulus(1'b1, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 10);
      applyStimulus(1'b0, 1'b1, 5);
      applyStimulus(1'b0, 1'b0, 120);

      $display("[TB] one-cycle lock loss in run");
      applyStimulus(1'b1, 1'b0, 2);
      applyStimulus(1'b0, 1'b1, 30);
      applyStimulus(1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 30);

      $display("[TB] reset while running");
      applyStimulus(1'b1, 1'b1, 1);
      applyStimulus(1'b0, 1'b1, 30);

      $display("[TB] loss counter saturation");
      for (int i = 0; i < 260; i++) begin
         applyStimulus(1'b0, 1'b0, 4);
         applyStimulus(1'b0, 1'b1, 20);
      end

      $display("[TB] random lock activity");
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 15) == 0) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1);
         applyStimulus(1'b0, ($urandom_range(0, 3) != 0), $urandom_range(1, 140));
      end

      @(negedge refclk);
      #1;
      n_compared++;
      if (exp_q.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL drain: got %0d pending, want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
